// File: rtl/dafx_pkg.sv
// Shared types and constants for the DAFX mixing datapath.
package dafx_pkg;

  // 125 MHz system clock / 10 kHz host sampling rate
  localparam int SAMPLING_IRQ_COUNTER_C = 12500;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUTPUT
  } sched_state_t;

endpackage

// File: rtl/dafx_sample_tick.sv
// Programmable sample-rate tick generator: one-cycle tick every 'period' clocks.
module dafx_sample_tick #(
  parameter int PERIOD_WIDTH_P   = 32,
  parameter int DEFAULT_PERIOD_P = 12500
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [PERIOD_WIDTH_P-1:0] sample_period,
  output logic                      tick
);

  logic [PERIOD_WIDTH_P-1:0] period_q;
  logic [PERIOD_WIDTH_P-1:0] count_q;
  logic [PERIOD_WIDTH_P-1:0] period_clamped;

  assign period_clamped = (sample_period < PERIOD_WIDTH_P'(2)) ? PERIOD_WIDTH_P'(2) : sample_period;
  assign tick           = enable && (count_q == period_q - PERIOD_WIDTH_P'(1));

  // The period is only reloaded on wrap, so a change never shortens or stretches a sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      period_q <= PERIOD_WIDTH_P'(DEFAULT_PERIOD_P);
      count_q  <= '0;
    end else if (!enable) begin
      count_q <= '0;
    end else if (tick) begin
      count_q  <= '0;
      period_q <= period_clamped;
    end else begin
      count_q <= count_q + PERIOD_WIDTH_P'(1);
    end
  end

endmodule

// File: rtl/dafx_sample_scheduler.sv
// Per-sample sequencer: snapshots channels on each tick, scales them through a shared
// multiplier one at a time, and emits one saturated mix sample plus a host IRQ.
module dafx_sample_scheduler
  import dafx_pkg::*;
#(
  parameter int NR_OF_CHANNELS_P = 3,
  parameter int AUDIO_WIDTH_P    = 24,
  parameter int GAIN_WIDTH_P     = 24,
  parameter int Q_BITS_P         = 11,
  parameter int PERIOD_WIDTH_P   = 32,
  parameter int DEFAULT_PERIOD_P = SAMPLING_IRQ_COUNTER_C
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     cr_enable,
  input  logic [PERIOD_WIDTH_P-1:0]                cr_sample_period,
  input  logic [NR_OF_CHANNELS_P*GAIN_WIDTH_P-1:0]  cr_gain,
  input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] ch_data,
  output logic                                     mul_valid,
  input  logic                                     mul_ready,
  output logic [AUDIO_WIDTH_P-1:0]                 mul_a,
  output logic [GAIN_WIDTH_P-1:0]                  mul_b,
  input  logic                                     mul_res_valid,
  input  logic [AUDIO_WIDTH_P+GAIN_WIDTH_P-1:0]    mul_res,
  output logic                                     mix_valid,
  output logic [AUDIO_WIDTH_P-1:0]                 mix_data,
  output logic                                     irq_sample,
  output logic [31:0]                              sr_sample_count,
  output logic [15:0]                              sr_overrun_count
);

  localparam int PROD_W = AUDIO_WIDTH_P + GAIN_WIDTH_P;
  localparam int ACC_W  = PROD_W + $clog2(NR_OF_CHANNELS_P) + 1;
  localparam int IDX_W  = (NR_OF_CHANNELS_P > 1) ? $clog2(NR_OF_CHANNELS_P) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(NR_OF_CHANNELS_P - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX_C =
    {{(ACC_W-AUDIO_WIDTH_P+1){1'b0}}, {(AUDIO_WIDTH_P-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN_C =
    {{(ACC_W-AUDIO_WIDTH_P+1){1'b1}}, {(AUDIO_WIDTH_P-1){1'b0}}};

  sched_state_t state_q, state_d;
  logic                     tick;
  logic [IDX_W-1:0]         idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [PROD_W-1:0] prod_shift;
  logic [AUDIO_WIDTH_P-1:0] data_q [NR_OF_CHANNELS_P];
  logic [GAIN_WIDTH_P-1:0]  gain_q [NR_OF_CHANNELS_P];

  dafx_sample_tick #(
    .PERIOD_WIDTH_P  (PERIOD_WIDTH_P),
    .DEFAULT_PERIOD_P(DEFAULT_PERIOD_P)
  ) u_tick (
    .clk          (clk),
    .rst          (rst),
    .enable       (cr_enable),
    .sample_period(cr_sample_period),
    .tick         (tick)
  );

  function automatic logic [AUDIO_WIDTH_P-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX_C) return SAT_MAX_C[AUDIO_WIDTH_P-1:0];
    if (v < SAT_MIN_C) return SAT_MIN_C[AUDIO_WIDTH_P-1:0];
    return v[AUDIO_WIDTH_P-1:0];
  endfunction

  // Arithmetic shift floors the Q-format product toward -inf.
  assign prod_shift = $signed(mul_res) >>> Q_BITS_P;
  assign mul_valid  = (state_q == ISSUE);
  assign mul_a      = data_q[idx_q];
  assign mul_b      = gain_q[idx_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: state_d gets its default first so no path through the case infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = ISSUE;
      ISSUE:   if (mul_ready) state_d = WAIT;
      WAIT:    if (mul_res_valid) state_d = (idx_q == LAST_IDX_C) ? OUTPUT : ISSUE;
      OUTPUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the small snapshot arrays are reset so the multiplier operands read 0 out of reset.
      for (int i = 0; i < NR_OF_CHANNELS_P; i++) begin
        data_q[i] <= '0;
        gain_q[i] <= '0;
      end
      idx_q            <= '0;
      acc_q            <= '0;
      mix_valid        <= 1'b0;
      irq_sample       <= 1'b0;
      mix_data         <= '0;
      sr_sample_count  <= '0;
      sr_overrun_count <= '0;
    end else begin
      mix_valid  <= 1'b0;
      irq_sample <= 1'b0;
      case (state_q)
        IDLE: if (tick) begin
          for (int i = 0; i < NR_OF_CHANNELS_P; i++) begin
            data_q[i] <= ch_data[i*AUDIO_WIDTH_P +: AUDIO_WIDTH_P];
            gain_q[i] <= cr_gain[i*GAIN_WIDTH_P +: GAIN_WIDTH_P];
          end
          idx_q <= '0;
          acc_q <= '0;
        end
        WAIT: if (mul_res_valid) begin
          acc_q <= acc_q + {{(ACC_W-PROD_W){prod_shift[PROD_W-1]}}, prod_shift};
          if (idx_q != LAST_IDX_C) idx_q <= idx_q + IDX_W'(1);
        end
        OUTPUT: begin
          mix_data        <= sat(acc_q);
          mix_valid       <= 1'b1;
          irq_sample      <= 1'b1;
          sr_sample_count <= sr_sample_count + 32'd1;
        end
        default: ;
      endcase
      // A tick that lands while a sequence is still in flight is dropped and counted.
      if (tick && (state_q != IDLE) && (sr_overrun_count != 16'hFFFF))
        sr_overrun_count <= sr_overrun_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dafx_sample_scheduler.sv
// Self-checking bench for dafx_sample_scheduler: directed scenarios plus a per-cycle
// comparison against a behavioural mix model and a 1-cycle (or slower) multiplier model.
module tb_dafx_sample_scheduler;

  localparam int N  = 3;
  localparam int AW = 24;
  localparam int GW = 24;

  logic              clk;
  logic              rst;
  logic              cr_enable;
  logic [31:0]       cr_sample_period;
  logic [N*GW-1:0]   cr_gain;
  logic [N*AW-1:0]   ch_data;
  logic              mul_valid;
  logic              mul_ready;
  logic [AW-1:0]     mul_a;
  logic [GW-1:0]     mul_b;
  logic              mul_res_valid;
  logic [AW+GW-1:0]  mul_res;
  logic              mix_valid;
  logic [AW-1:0]     mix_data;
  logic              irq_sample;
  logic [31:0]       sr_sample_count;
  logic [15:0]       sr_overrun_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int res_lat  = 1;
  int res_cnt  = 0;
  int data[N];
  int gain[N];

  dafx_sample_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .cr_enable       (cr_enable),
    .cr_sample_period(cr_sample_period),
    .cr_gain         (cr_gain),
    .ch_data         (ch_data),
    .mul_valid       (mul_valid),
    .mul_ready       (mul_ready),
    .mul_a           (mul_a),
    .mul_b           (mul_b),
    .mul_res_valid   (mul_res_valid),
    .mul_res         (mul_res),
    .mix_valid       (mix_valid),
    .mix_data        (mix_data),
    .irq_sample      (irq_sample),
    .sr_sample_count (sr_sample_count),
    .sr_overrun_count(sr_overrun_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not end, got cycle %0d required < 60000", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Mix of one sample: sum of floor(d*g / 2^11), clamped to the 24-bit signed range.
  function automatic int exp_mix(input int d[N], input int g[N]);
    longint acc = 0;
    for (int i = 0; i < N; i++) acc += (longint'(d[i]) * longint'(g[i])) >>> 11;
    if (acc > 64'sd8388607) acc = 64'sd8388607;
    else if (acc < -64'sd8388608) acc = -64'sd8388608;
    return int'(acc);
  endfunction

  task automatic set_ch(input int d0, input int d1, input int d2,
                        input int g0, input int g1, input int g2);
    data[0] = d0; data[1] = d1; data[2] = d2;
    gain[0] = g0; gain[1] = g1; gain[2] = g2;
    for (int i = 0; i < N; i++) begin
      ch_data[i*AW +: AW] = AW'(data[i]);
      cr_gain[i*GW +: GW] = GW'(gain[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mix(input int budget, output int c, output int v);
    c = -1;
    v = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (mix_valid) begin
        c = cyc;
        v = int'($signed(mix_data));
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL mix_timeout: got no mix_valid within %0d cycles, required one", budget);
  endtask

  // Shared multiplier model: one product per accepted request, res_lat cycles later.
  initial begin
    mul_res_valid = 1'b0;
    mul_res       = '0;
    forever begin
      @(negedge clk);
      mul_res_valid = 1'b0;
      if (res_cnt > 0) begin
        res_cnt--;
        if (res_cnt == 0) mul_res_valid = 1'b1;
      end
      if (mul_valid && mul_ready) begin
        res_cnt = res_lat;
        mul_res = (AW+GW)'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
      end
    end
  end

  // Per-cycle compare against the behavioural model.
  initial begin
    int  prev_d[N], prev_g[N], snap_d[N], snap_g[N];
    bit  in_sample = 0;
    bit  stalled   = 0;
    int  req_cnt = 0, first_cyc = 0, model_count = 0, last_mix = 0, e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_pulses", longint'({mix_valid, irq_sample, mul_valid}), 0);
        check("rst_mix_data", longint'(mix_data), 0);
        check("rst_counters", longint'({sr_sample_count, sr_overrun_count}), 0);
        check("rst_operands", longint'({mul_a, mul_b}), 0);
        in_sample   = 0;
        model_count = 0;
        last_mix    = 0;
      end else begin
        check("irq_with_mix", longint'(irq_sample), longint'(mix_valid));
        if (mix_valid) begin
          e = exp_mix(snap_d, snap_g);
          check("mix_data", longint'($signed(mix_data)), longint'(e));
          check("mix_in_sample", longint'(in_sample), 1);
          check("requests_per_mix", req_cnt, N);
          if (!stalled) check("mix_latency", cyc - first_cyc, 2*N + 1);
          model_count++;
          last_mix  = e;
          in_sample = 0;
        end else begin
          check("mix_hold", longint'($signed(mix_data)), longint'(last_mix));
        end
        check("sample_count", longint'(sr_sample_count), longint'(model_count));
        if (mul_valid) begin
          if (!in_sample) begin
            snap_d    = prev_d;
            snap_g    = prev_g;
            in_sample = 1;
            req_cnt   = 0;
            first_cyc = cyc;
            stalled   = (res_lat != 1);
          end
          check("request_index", longint'(req_cnt < N), 1);
          if (req_cnt < N) begin
            check("mul_a", longint'($signed(mul_a)), longint'(snap_d[req_cnt]));
            check("mul_b", longint'($signed(mul_b)), longint'(snap_g[req_cnt]));
          end
          if (!mul_ready) stalled = 1;
          else req_cnt++;
        end
      end
      prev_d = data;
      prev_g = gain;
    end
  end

  initial begin
    int c, v, c_prev, r0, ov_a, e0;
    bit found;
    rst              = 1'b1;
    cr_enable        = 1'b0;
    cr_sample_period = 32'd8;
    mul_ready        = 1'b1;
    set_ch(100, 200, 300, 2048, 2048, 2048);
    repeat (3) @(negedge clk);
    check("reset_sample_count", longint'(sr_sample_count), 0);

    // Default period of 12500 applies to the first interval; 8 is loaded at its wrap.
    step();
    rst       = 1'b0;
    cr_enable = 1'b1;
    r0        = cyc;
    wait_mix(13000, c, v);
    check("first_mix_delay", c - r0, 12507);
    check("first_mix_600", v, 600);
    for (int k = 0; k < 3; k++) begin
      c_prev = c;
      wait_mix(40, c, v);
      check("interval_8", c - c_prev, 8);
      check("mix_600", v, 600);
    end
    check("count_after_4", longint'(sr_sample_count), 4);

    step(); set_ch(-1000, 0, 0, 1024, 2048, 2048);
    wait_mix(40, c, v); wait_mix(40, c, v);
    check("mix_minus_500", v, -500);
    step(); set_ch(-1, 0, 0, 1024, 2048, 2048);
    wait_mix(40, c, v); wait_mix(40, c, v);
    check("mix_floor_minus_1", v, -1);
    step(); set_ch(8388607, 8388607, 8388607, 2048, 2048, 2048);
    wait_mix(40, c, v); wait_mix(40, c, v);
    check("sat_positive", v, 8388607);
    step(); set_ch(-8388608, -8388608, -8388608, 2048, 2048, 2048);
    wait_mix(40, c, v); wait_mix(40, c, v);
    check("sat_negative", v, -8388608);
    check("no_overrun_yet", longint'(sr_overrun_count), 0);

    // Stall: restart the tick from idle with the multiplier refusing for 20 cycles.
    step(); cr_enable = 1'b0;
    wait_mix(40, c, v);
    step();
    cr_enable = 1'b1;
    mul_ready = 1'b0;
    set_ch(1000, -2000, 3000, 2048, 1024, 4096);
    r0 = cyc;
    repeat (10) step();
    set_ch(7, 7, 7, 2048, 2048, 2048);
    repeat (10) step();
    mul_ready = 1'b1;
    wait_mix(40, c, v);
    check("stall_mix_delay", c - r0, 27);
    check("stall_mix_6000", v, 6000);
    check("stall_overruns", longint'(sr_overrun_count), 2);

    // Period change mid-count takes effect only after the current interval.
    wait_mix(40, c, v);
    repeat (3) step();
    cr_sample_period = 32'd16;
    wait_mix(40, c, v);
    c_prev = c;
    wait_mix(40, c, v);
    check("interval_kept_8", c - c_prev, 8);
    c_prev = c;
    wait_mix(40, c, v);
    check("interval_now_16", c - c_prev, 16);

    // Period 0 is clamped to 2: three dropped ticks per 8-cycle sequence.
    cr_sample_period = 32'd0;
    wait_mix(40, c, v); wait_mix(40, c, v);
    c_prev = c;
    ov_a   = int'(sr_overrun_count);
    wait_mix(40, c, v);
    check("interval_period_2", c - c_prev, 8);
    check("overruns_period_2", longint'(sr_overrun_count) - ov_a, 3);
    e0 = exp_mix(data, gain);
    check("mix_period_2", v, e0);

    // Reset while waiting on a slow product; the late result must be ignored.
    cr_sample_period = 32'd8;
    res_lat = 4;
    found   = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (mul_valid && mul_ready) found = 1;
    end
    check("accept_before_reset", longint'(found), 1);
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    res_lat = 1;
    r0      = cyc;
    wait_mix(13000, c, v);
    check("mix_delay_after_reset", c - r0, 12507);
    check("mix_after_reset", v, exp_mix(data, gain));
    check("count_after_reset", longint'(sr_sample_count), 1);
    check("overrun_after_reset", longint'(sr_overrun_count), 0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dafx_sample_scheduler.md
Name: dafx_sample_scheduler

Overview:
Per-sample sequencer for the DAFX mixing datapath. A programmable tick counter derives the host sampling rate from the system clock (default 125 MHz / 10 kHz = 12500 cycles). On each tick it snapshots all channel samples and gains, then steps them one at a time through a shared external signed multiplier via a valid/ready handshake. It accumulates the scaled products and emits one saturated mix sample together with a host IRQ pulse.

Parameters:
NR_OF_CHANNELS_P, 3, number of channels sequenced per sample (>=1)
AUDIO_WIDTH_P, 24, signed sample width
GAIN_WIDTH_P, 24, signed gain width, fixed point
Q_BITS_P, 11, fractional bits of gain (1.0 = 2048)
PERIOD_WIDTH_P, 32, width of sample-period register
DEFAULT_PERIOD_P, 12500, period loaded at reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cr_enable  in  1  tick counter run enable
cr_sample_period  in  PERIOD_WIDTH_P  clock cycles per sample; values <2 treated as 2
cr_gain  in  NR_OF_CHANNELS_P*GAIN_WIDTH_P  packed gains, channel 0 in LSBs
ch_data  in  NR_OF_CHANNELS_P*AUDIO_WIDTH_P  packed live channel samples
mul_valid  out  1  operand request to shared multiplier
mul_ready  in  1  multiplier accepts operands
mul_a  out  AUDIO_WIDTH_P  signed sample operand
mul_b  out  GAIN_WIDTH_P  signed gain operand
mul_res_valid  in  1  product valid (one pulse per accepted request)
mul_res  in  AUDIO_WIDTH_P+GAIN_WIDTH_P  signed product
mix_valid  out  1  one-cycle pulse, mix_data valid
mix_data  out  AUDIO_WIDTH_P  saturated mix sample
irq_sample  out  1  one-cycle pulse, coincident with mix_valid
sr_sample_count  out  32  completed samples, wraps at 2^32
sr_overrun_count  out  16  ticks dropped while busy, saturates at 0xFFFF

Behaviour:
- Reset is asynchronous and active-high. All outputs reset to 0 and the FSM goes to IDLE. Tick counter resets to 0, and the period register loads DEFAULT_PERIOD_P.
- Period register: cr_sample_period (clamped to >=2) is captured only when the tick counter wraps, so a period change never produces a short or long sample.
- Tick counter: increments while cr_enable=1. When it reaches period-1, tick pulses for one cycle and the counter returns to 0. With cr_enable=0 the counter is held at 0 and no ticks occur; an in-flight sequence still completes.
- FSM states:
  - IDLE: on tick, register ch_data and cr_gain, set idx=0, clear acc, go to ISSUE.
  - ISSUE: mul_valid=1 with mul_a=data[idx], mul_b=gain[idx]; operands are stable while mul_valid=1 and mul_ready=0. On mul_valid&&mul_ready go to WAIT.
  - WAIT: on mul_res_valid, acc += mul_res >>> Q_BITS_P (arithmetic shift, truncation toward -inf). If idx==NR_OF_CHANNELS_P-1 go to OUTPUT; otherwise idx++ and go to ISSUE. mul_res_valid outside WAIT is ignored.
  - OUTPUT: mix_data <= sat(acc). mix_valid, irq_sample and sr_sample_count++ are registered and appear together for one cycle. Then return to IDLE.
- Width rules:
  - acc is signed, AUDIO_WIDTH_P+GAIN_WIDTH_P+clog2(NR_OF_CHANNELS_P)+1 bits, so it cannot overflow.
  - sat() clamps to [-2^(AUDIO_WIDTH_P-1), 2^(AUDIO_WIDTH_P-1)-1].
- Latency: with mul_ready=1 and results arriving 1 cycle after acceptance, mix_valid occurs 2*NR_OF_CHANNELS_P+2 cycles after the tick cycle.
- Overrun: a tick while FSM != IDLE is dropped and sr_overrun_count increments (saturating). A tick in the same cycle the FSM returns to IDLE counts as an overrun.
- mix_data holds its value between pulses.

Decomposition:
- Shared package dafx_pkg gains: sched_state_t enum (IDLE, ISSUE, WAIT, OUTPUT), and SAMPLING_IRQ_COUNTER_C used as DEFAULT_PERIOD_P.
- One sub-module: dafx_sample_tick (period register, clamp, tick counter, enable), instantiated once.

Test Plan:
- Period 8, enable, gains all 2048, data 100/200/300, mul_ready=1, 1-cycle result: mix_data=600 every 8 cycles, irq_sample coincident, sr_sample_count increments by 1 per sample.
- Data -1000/0/0, gain0=1024: mix_data=-500. Data -1, gain0=1024: mix_data=-1 (floor rounding).
- Data 0x7FFFFF on all 3 channels, gains 2048: mix_data=0x7FFFFF. All data 0x800000: mix_data=0x800000 (saturation).
- Period 8, mul_ready held 0 for 20 cycles: operands stable throughout, sr_overrun_count=2, then one correct mix.
- Period changed from 8 to 16 mid-count: current interval stays 8, next interval 16. cr_sample_period=0 gives a tick every 2 cycles.
- rst asserted while in WAIT: outputs 0 immediately, no mix_valid, late mul_res_valid ignored, normal operation resumes from IDLE.
